// File: rtl/dma_length_counter_pkg.sv
// Shared types and constants for the Sound Blaster DSP DMA length counter.
package dma_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2
  } dma_state_t;

  localparam int unsigned DMA_WIDTH_DEFAULT = 16;

  // Byte lanes of the base register addressed by len_wr_lo / len_wr_hi.
  localparam int unsigned LANE_BITS = 8;
  localparam int unsigned LANE_LO   = 0;
  localparam int unsigned LANE_HI   = 1;

endpackage

// File: rtl/dma_length_counter_down_counter.sv
// WIDTH-bit down counter with synchronous preset; holds at zero instead of wrapping.
module down_counter
  import dma_pkg::*;
#(
  parameter int unsigned WIDTH = DMA_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load_n,
  input  logic [WIDTH-1:0] d,
  input  logic             en,
  output logic [WIDTH-1:0] q,
  output logic             zero_n
);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      q <= '0;
    end else if (!load_n) begin
      q <= d;
    end else if (en && (q != '0)) begin
      q <= q - WIDTH'(1);
    end
  end

  assign zero_n = |q;

endmodule

// File: rtl/dma_length_counter.sv
// DMA transfer-length counter: byte-wise programmed base, one drq per byte, tc/irq at terminal count.
// Auto-init reload is present only when DMA_AUTOINIT_EN is defined.
module dma_length_counter
  import dma_pkg::*;
#(
  parameter int unsigned WIDTH = DMA_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             len_wr_lo,
  input  logic             len_wr_hi,
  input  logic [7:0]       len_data,
  input  logic             start,
  input  logic             autoinit,
  input  logic             pause,
  input  logic             resume,
  input  logic             stop,
  input  logic             ack,
  input  logic             irq_clr,
  output logic             drq,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             irq,
  output logic             busy
);

  dma_state_t           state, state_next;
  logic [LANE_BITS-1:0] base_lane [2];
  logic [WIDTH-1:0]     base;
  logic [WIDTH-1:0]     cnt_q;
  logic                 cnt_zero_n;
  logic                 cnt_load_n;
  logic                 cnt_en;
  logic                 mode_auto;
  logic                 start_go;
  logic                 run_ack;
  logic                 term_ack;
  logic                 drq_d, busy_d, tc_d, irq_d;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      base_lane[LANE_LO] <= '0;
      base_lane[LANE_HI] <= '0;
    end else begin
      if (len_wr_lo) base_lane[LANE_LO] <= len_data;
      if (len_wr_hi) base_lane[LANE_HI] <= len_data;
    end
  end

  // Lanes above the high byte are never written and read as zero.
  generate
    if (WIDTH == 8) begin : g_base8
      logic hi_lane_unused;
      assign hi_lane_unused = ^base_lane[LANE_HI];
      assign base = base_lane[LANE_LO];
    end else if (WIDTH == 16) begin : g_base16
      assign base = {base_lane[LANE_HI], base_lane[LANE_LO]};
    end else begin : g_basewide
      assign base = {{(WIDTH-16){1'b0}}, base_lane[LANE_HI], base_lane[LANE_LO]};
    end
  endgenerate

  // stop outranks start, and both outrank ack.
  assign start_go = start && !stop;
  assign run_ack  = (state == RUN) && ack && !stop && !start;
  assign term_ack = run_ack && !cnt_zero_n;
  assign cnt_en   = run_ack;

`ifdef DMA_AUTOINIT_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mode_auto <= 1'b0;
    end else if (start_go) begin
      mode_auto <= autoinit;
    end
  end

  assign cnt_load_n = !(start_go || (term_ack && mode_auto));
`else
  logic autoinit_unused;
  assign autoinit_unused = autoinit;
  assign mode_auto       = 1'b0;
  assign cnt_load_n      = !start_go;
`endif

  down_counter #(
    .WIDTH (WIDTH)
  ) u_down_counter (
    .clk     (clk),
    .reset_n (reset_n),
    .load_n  (cnt_load_n),
    .d       (base),
    .en      (cnt_en),
    .q       (cnt_q),
    .zero_n  (cnt_zero_n)
  );

  assign count = cnt_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      drq   <= 1'b0;
      busy  <= 1'b0;
      tc    <= 1'b0;
      irq   <= 1'b0;
    end else begin
      state <= state_next;
      drq   <= drq_d;
      busy  <= busy_d;
      tc    <= tc_d;
      irq   <= irq_d;
    end
  end

  // A terminal ack is counted before pause is honoured, so a single-cycle
  // run ending with pause lands in IDLE rather than PAUSED.
  always_comb begin
    state_next = state;
    if (stop) begin
      state_next = IDLE;
    end else if (start) begin
      state_next = RUN;
    end else begin
      unique case (state)
        RUN: begin
          if (term_ack && !mode_auto) begin
            state_next = IDLE;
          end else if (pause) begin
            state_next = PAUSED;
          end
        end
        PAUSED: begin
          if (resume) state_next = RUN;
        end
        default: state_next = state;
      endcase
    end
  end

  always_comb begin
    drq_d  = (state_next == RUN);
    busy_d = (state_next != IDLE);
    tc_d   = term_ack;
    irq_d  = term_ack || (irq && !irq_clr);
  end

endmodule

// File: doc/dma_length_counter.md
# dma_length_counter

DMA transfer-length counter for the Sound Blaster DSP path on the riser. The DSP command decoder programs a base length byte-wise. The block then requests one ISA DMA transfer at a time and counts down once per acknowledged byte. At terminal count it raises a terminal-count pulse and a sticky interrupt, then either stops (single-cycle) or reloads and continues (auto-init). It is the decrementing counterpart of the existing upward counter and sits between the DSP command decoder and the DMA request/acknowledge logic.

## Interface
- WIDTH, 16, width of base and current count registers; must be a multiple of 8, minimum 8
- clk  in  1  system clock; all state changes on rising edge
- reset_n  in  1  reset, synchronous, active-low
- len_wr_lo  in  1  write len_data into base[7:0]
- len_wr_hi  in  1  write len_data into base[15:8]; WIDTH>16 upper bytes stay zero
- len_data  in  8  length byte from DSP command decoder
- start  in  1  load current count from base and enter RUN
- autoinit  in  1  sampled on start; selects auto-init mode for the run
- pause  in  1  RUN -> PAUSED
- resume  in  1  PAUSED -> RUN
- stop  in  1  abort from any state to IDLE
- ack  in  1  one DMA byte transferred (one-cycle pulse per byte)
- irq_clr  in  1  clear sticky irq
- drq  out  1  DMA request; high only in RUN
- count  out  WIDTH  current remaining count minus one
- tc  out  1  one-cycle terminal-count pulse
- irq  out  1  sticky interrupt, set on tc
- busy  out  1  high in RUN or PAUSED

## Operation
- States: IDLE, RUN, PAUSED.
- Reset values: state IDLE, base 0, count 0, mode_auto 0, drq 0, tc 0, irq 0, busy 0.
- Base writes are accepted in any state. During a run they affect only the next reload or start, never the live count.
- start in any state: count <= base, mode_auto <= autoinit, state <= RUN. Restart mid-run is legal.
- A run transfers base+1 bytes. base=0 means 1 byte; base=0xFFFF means 65536 bytes.
- ack in RUN with count!=0: count <= count-1.
- ack in RUN with count==0 (terminal):
  - tc pulses and irq sets.
  - With mode_auto, count <= base and the block stays in RUN.
  - Without mode_auto, state <= IDLE and count holds 0.
- ack outside RUN is ignored and never decrements.
- Count never wraps below 0. Terminal detection replaces the borrow.
- pause in RUN -> PAUSED: drq drops and count holds. resume in PAUSED -> RUN. Each is ignored in other states.
- stop: state <= IDLE and count holds its value. irq is untouched.
- Priority when inputs coincide: reset_n > stop > start > ack > pause/resume.
- ack together with pause in RUN: the ack is counted, then the state becomes PAUSED. A terminal ack together with pause in single-cycle mode ends in IDLE.
- irq: set by tc, cleared by irq_clr. When both occur in the same cycle, set wins.

## Timing
- All outputs are registered.
- drq rises the cycle after start and falls the cycle after pause, stop or a single-cycle terminal ack.
- count updates the cycle after ack.
- tc is high for exactly the cycle after the terminal ack. irq rises in the same cycle as tc.
- Back-to-back acks on consecutive cycles are supported with no dead cycles, including across an auto-init reload.

## Configuration
- DMA_AUTOINIT_EN defined: auto-init behaves as above.
- DMA_AUTOINIT_EN undefined:
  - The autoinit input is ignored and mode_auto is tied to 0.
  - Every run is single-cycle and terminates in IDLE.
  - The reload path is removed.

## Structure
- Package dma_pkg holds:
  - the state enum typedef (IDLE, RUN, PAUSED)
  - the default WIDTH constant
  - byte-lane select constants for len_wr_lo/hi
- Sub-module down_counter: WIDTH-bit down counter with synchronous reset_n, load_n/D preset, enable, and zero flag zero_n. It holds at 0 rather than wrapping. It mirrors the existing upward counter.

## Test plan
- base=0x0003, start, ack every cycle -> count 3,2,1,0; tc once after 4th ack; drq low next cycle; irq=1; state IDLE.
- DMA_AUTOINIT_EN set, base=0x0001, start with autoinit=1, 6 acks -> tc after acks 2, 4, 6; drq stays high; count reloads to 1 each time.
- base=0x0005, start, 2 acks, pause, 3 acks, resume, 1 ack -> acks during PAUSED ignored; count=2 after resume ack; drq low only while paused.
- irq_clr in the same cycle as a terminal ack -> irq remains 1. irq_clr one cycle later -> irq 0.
- Auto-init run, write base=0x0002 mid-run -> current count unaffected; after next tc, count reloads to 2.
- reset_n low during RUN with count=0x1234 -> next cycle all outputs at reset values; subsequent ack ignored.
